// File: rtl/tod_snapshot_reader_if.sv
// Register-read bus between the decode logic (master) and the snapshot reader (slave).
// RD_REQ is a one-cycle strobe that is always accepted (no ready); RD_VALID_Q answers it exactly one cycle later.
interface tod_snapshot_reader_if #(
   parameter int P_ADDR_WIDTH = 2,
   parameter int P_BUS_WIDTH  = 16
);
   logic                    RD_REQ;
   logic [P_ADDR_WIDTH-1:0] RD_ADDR;
   logic [P_BUS_WIDTH-1:0]  RD_DATA_Q;
   logic                    RD_VALID_Q;

   modport master (
      output RD_REQ,
      output RD_ADDR,
      input  RD_DATA_Q,
      input  RD_VALID_Q
   );

   modport slave (
      input  RD_REQ,
      input  RD_ADDR,
      output RD_DATA_Q,
      output RD_VALID_Q
   );
endinterface

// File: rtl/tod_snapshot_reader.sv
// Serves a wide time-of-day counter over a narrow read bus; a word-0 read freezes the
// whole value into a shadow so the remaining words never tear across a carry.
module tod_snapshot_reader #(
   parameter int P_CNTR_WIDTH = 48,
   parameter int P_BUS_WIDTH  = 16,
   parameter int P_ADDR_WIDTH = 2,
   parameter int P_TIMEOUT    = 255
) (
   input  logic                    CLOCK,
   input  logic                    RESET_N,
   input  logic [P_CNTR_WIDTH-1:0] CNTR_IN,
   input  logic                    ERR_CLR,
   output logic                    SNAP_ACTIVE_Q,
   output logic                    ERR_STALE_Q,
   tod_snapshot_reader_if.slave    rd
);

   localparam int LP_N     = (P_CNTR_WIDTH + P_BUS_WIDTH - 1) / P_BUS_WIDTH;
   localparam int LP_PAD_W = LP_N * P_BUS_WIDTH;
   localparam logic [P_ADDR_WIDTH:0] LP_N_A    = (P_ADDR_WIDTH+1)'(LP_N);
   localparam logic [P_ADDR_WIDTH:0] LP_LAST_A = (P_ADDR_WIDTH+1)'(LP_N - 1);
   localparam logic [15:0]           LP_TMO    = 16'(P_TIMEOUT);

   typedef enum logic {ST_IDLE, ST_CAPTURED} state_t;

   state_t                  state_q;
   logic [P_CNTR_WIDTH-1:0] shadow_q;
   logic [P_BUS_WIDTH-1:0]  data_q;
   logic                    valid_q;
   logic                    err_q;
   logic [15:0]             tmo_cnt_q;

   logic [15:0]             tmo_cnt_d;
   logic [LP_PAD_W-1:0]     live_pad;
   logic [LP_PAD_W-1:0]     shadow_pad;
   logic [P_ADDR_WIDTH:0]   addr_ext;
   logic                    in_range;
   logic                    is_word0;
   logic                    is_last;
   logic                    set_err;
   logic [P_BUS_WIDTH-1:0]  live_word;
   logic [P_BUS_WIDTH-1:0]  shadow_word;

   // Zero-padding to a whole number of words makes the top word read 0 above the counter MSB.
   always_comb begin
      live_pad                       = '0;
      live_pad[P_CNTR_WIDTH-1:0]     = CNTR_IN;
      shadow_pad                     = '0;
      shadow_pad[P_CNTR_WIDTH-1:0]   = shadow_q;
      addr_ext                       = {1'b0, rd.RD_ADDR};
      in_range                       = (addr_ext < LP_N_A);
      is_word0                       = (addr_ext == '0);
      is_last                        = (addr_ext == LP_LAST_A);
      live_word                      = '0;
      shadow_word                    = '0;
      for (int k = 0; k < LP_N; k++) begin
         if (addr_ext == (P_ADDR_WIDTH+1)'(k)) begin
            live_word   = live_pad[k*P_BUS_WIDTH +: P_BUS_WIDTH];
            shadow_word = shadow_pad[k*P_BUS_WIDTH +: P_BUS_WIDTH];
         end
      end
      set_err   = rd.RD_REQ && in_range && !is_word0 && (state_q == ST_IDLE);
      tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         valid_q <= rd.RD_REQ;

         if (rd.RD_REQ && is_word0) begin
            shadow_q <= CNTR_IN;
            data_q   <= live_word;
            if (LP_N > 1) begin
               state_q   <= ST_CAPTURED;
               tmo_cnt_q <= '0;
            end
         end else if (rd.RD_REQ && in_range) begin
            if (state_q == ST_CAPTURED) begin
               data_q <= shadow_word;
               if (is_last) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmo_cnt_q <= '0;
               end
            end else begin
               data_q <= live_word;
            end
         end else begin
            // Out-of-range reads answer 0 and count as idle for the abandonment timer.
            if (rd.RD_REQ) begin
               data_q <= '0;
            end
            if (state_q == ST_CAPTURED) begin
               tmo_cnt_q <= tmo_cnt_d;
               if (tmo_cnt_d == LP_TMO) begin
                  state_q <= ST_IDLE;
               end
            end
         end

         if (set_err) begin
            err_q <= 1'b1;
         end else if (ERR_CLR) begin
            err_q <= 1'b0;
         end
      end
   end

   assign rd.RD_DATA_Q  = data_q;
   assign rd.RD_VALID_Q = valid_q;
   assign SNAP_ACTIVE_Q = (state_q == ST_CAPTURED);
   assign ERR_STALE_Q   = err_q;

endmodule

// File: tb/tb_tod_snapshot_reader.sv
// Bench for tod_snapshot_reader: directed vector table, hand-written reset corner,
// randomized traffic against a snapshot model, and a 40-bit width instance.
module tb_tod_snapshot_reader;

   localparam int TMO = 4;
   localparam int NW  = 3;

   logic        clk;
   logic        rst_n;
   logic [47:0] cntr_a;
   logic        clr_a;
   logic        active_a;
   logic        err_a;
   logic [39:0] cntr_b;
   logic        clr_b;
   logic        active_b;
   logic        err_b;

   int total;
   int bad;

   tod_snapshot_reader_if #(.P_ADDR_WIDTH(2), .P_BUS_WIDTH(16)) if_a ();
   tod_snapshot_reader_if #(.P_ADDR_WIDTH(2), .P_BUS_WIDTH(16)) if_b ();

   tod_snapshot_reader #(
      .P_CNTR_WIDTH(48), .P_BUS_WIDTH(16), .P_ADDR_WIDTH(2), .P_TIMEOUT(TMO)
   ) dut_a (
      .CLOCK(clk), .RESET_N(rst_n), .CNTR_IN(cntr_a), .ERR_CLR(clr_a),
      .SNAP_ACTIVE_Q(active_a), .ERR_STALE_Q(err_a), .rd(if_a)
   );

   tod_snapshot_reader #(
      .P_CNTR_WIDTH(40), .P_BUS_WIDTH(16), .P_ADDR_WIDTH(2), .P_TIMEOUT(255)
   ) dut_b (
      .CLOCK(clk), .RESET_N(rst_n), .CNTR_IN(cntr_b), .ERR_CLR(clr_b),
      .SNAP_ACTIVE_Q(active_b), .ERR_STALE_Q(err_b), .rd(if_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vector table
   typedef struct {
      logic        req;
      logic [1:0]  addr;
      logic [47:0] cntr;
      logic        clr;
      logic [15:0] exp_data;
      logic        exp_valid;
      logic        exp_active;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic req, logic [1:0] addr, logic [47:0] cntr, logic clr,
                               logic [15:0] d, logic v, logic a, logic e);
      vec_t r;
      r.req = req; r.addr = addr; r.cntr = cntr; r.clr = clr;
      r.exp_data = d; r.exp_valid = v; r.exp_active = a; r.exp_err = e;
      return r;
   endfunction

   // reference model: a snapshot is either held or not; idle cycles abandon it
   bit          m_snap;
   logic [47:0] m_shadow;
   int          m_idle;
   bit          m_err;
   logic [15:0] m_data;
   bit          m_valid;

   function automatic logic [15:0] word_of(logic [47:0] v, int k);
      logic [47:0] s;
      s = v >> (16 * k);
      return s[15:0];
   endfunction

   function automatic void model_reset();
      m_snap = 0; m_shadow = '0; m_idle = 0; m_err = 0; m_data = '0; m_valid = 0;
   endfunction

   function automatic void model_step(logic req, logic [1:0] addr, logic [47:0] cntr, logic clr);
      bit set_err;
      bit in_range_read;
      int a;
      a = int'(addr);
      set_err = 0;
      in_range_read = req && (a < NW);
      m_valid = req;
      if (req) begin
         if (a >= NW) begin
            m_data = '0;
         end else if (a == 0) begin
            m_shadow = cntr;
            m_data   = word_of(cntr, 0);
            m_snap   = 1;
            m_idle   = 0;
         end else if (m_snap) begin
            m_data = word_of(m_shadow, a);
            if (a == NW - 1) m_snap = 0;
            else m_idle = 0;
         end else begin
            m_data  = word_of(cntr, a);
            set_err = 1;
         end
      end
      if (m_snap && !in_range_read) begin
         m_idle = m_idle + 1;
         if (m_idle >= TMO) m_snap = 0;
      end
      if (set_err) m_err = 1;
      else if (clr) m_err = 0;
   endfunction

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(logic req, logic [1:0] addr, logic [47:0] cntr, logic clr);
      if_a.RD_REQ  = req;
      if_a.RD_ADDR = addr;
      cntr_a       = cntr;
      clr_a        = clr;
   endtask

   task automatic model_cycle(string tag, logic req, logic [1:0] addr, logic [47:0] cntr, logic clr);
      drive_a(req, addr, cntr, clr);
      model_step(req, addr, cntr, clr);
      tick();
      check({tag, "_data"},   if_a.RD_DATA_Q,  m_data);
      check({tag, "_valid"},  if_a.RD_VALID_Q, m_valid);
      check({tag, "_active"}, active_a,        m_snap);
      check({tag, "_err"},    err_a,           m_err);
   endtask

   task automatic drive_b(logic req, logic [1:0] addr, logic [15:0] d, logic a, string tag);
      if_b.RD_REQ  = req;
      if_b.RD_ADDR = addr;
      tick();
      check({tag, "_data"},   if_b.RD_DATA_Q,  d);
      check({tag, "_valid"},  if_b.RD_VALID_Q, req);
      check({tag, "_active"}, active_b,        a);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive_a(1'b0, 2'd0, '0, 1'b0);
      if_b.RD_REQ = 1'b0; if_b.RD_ADDR = 2'd0; cntr_b = '0; clr_b = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_data",   if_a.RD_DATA_Q,  16'h0);
      check("rst_valid",  if_a.RD_VALID_Q, 1'b0);
      check("rst_active", active_a,        1'b0);
      check("rst_err",    err_a,           1'b0);
      rst_n = 1'b1;

      // atomicity across a carry
      vecs.push_back(mk(1, 0, 48'h0000_FFFF_FFFF, 0, 16'hFFFF, 1, 1, 0));
      vecs.push_back(mk(0, 0, 48'h0001_0000_0000, 0, 16'hFFFF, 0, 1, 0));
      vecs.push_back(mk(1, 1, 48'h0001_0000_0000, 0, 16'hFFFF, 1, 1, 0));
      vecs.push_back(mk(1, 2, 48'h0001_0000_0000, 0, 16'h0000, 1, 0, 0));
      // back-to-back reads
      vecs.push_back(mk(1, 0, 48'h1234_5678_9ABC, 0, 16'h9ABC, 1, 1, 0));
      vecs.push_back(mk(1, 1, 48'hFFFF_FFFF_FFFF, 0, 16'h5678, 1, 1, 0));
      vecs.push_back(mk(1, 2, 48'hFFFF_FFFF_FFFF, 0, 16'h1234, 1, 0, 0));
      vecs.push_back(mk(0, 0, 48'hFFFF_FFFF_FFFF, 0, 16'h1234, 0, 0, 0));
      // stale read and clear priority
      vecs.push_back(mk(1, 1, 48'h0012_3456_789A, 0, 16'h3456, 1, 0, 1));
      vecs.push_back(mk(1, 1, 48'h0012_3456_789A, 1, 16'h3456, 1, 0, 1));
      vecs.push_back(mk(0, 0, 48'h0012_3456_789A, 1, 16'h3456, 0, 0, 0));
      // timeout after 4 idle cycles
      vecs.push_back(mk(1, 0, 48'h0005_0006_0007, 0, 16'h0007, 1, 1, 0));
      vecs.push_back(mk(0, 0, 48'h0005_0006_0007, 0, 16'h0007, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h0005_0006_0007, 0, 16'h0007, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h0005_0006_0007, 0, 16'h0007, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h0005_0006_0007, 0, 16'h0007, 0, 0, 0));
      vecs.push_back(mk(1, 1, 48'h0009_0008_0007, 0, 16'h0008, 1, 0, 1));
      vecs.push_back(mk(0, 0, 48'h0009_0008_0007, 1, 16'h0008, 0, 0, 0));
      // out-of-range reads do not hold off the timeout
      vecs.push_back(mk(1, 0, 48'h0005_0006_0007, 0, 16'h0007, 1, 1, 0));
      vecs.push_back(mk(1, 3, 48'h0005_0006_0007, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 3, 48'h0005_0006_0007, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 3, 48'h0005_0006_0007, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 3, 48'h0005_0006_0007, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(1, 2, 48'h0005_0006_0007, 0, 16'h0005, 1, 0, 1));
      vecs.push_back(mk(0, 0, 48'h0005_0006_0007, 1, 16'h0005, 0, 0, 0));
      // an in-range read restarts the timeout
      vecs.push_back(mk(1, 0, 48'h000A_000B_000C, 0, 16'h000C, 1, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000C, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000C, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000C, 0, 1, 0));
      vecs.push_back(mk(1, 1, 48'h000A_000B_000C, 0, 16'h000B, 1, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000B, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000B, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000B, 0, 1, 0));
      vecs.push_back(mk(0, 0, 48'h000A_000B_000C, 0, 16'h000B, 0, 0, 0));
      // re-capture replaces the shadow
      vecs.push_back(mk(1, 0, 48'h1111_2222_3333, 0, 16'h3333, 1, 1, 0));
      vecs.push_back(mk(1, 0, 48'h4444_5555_6666, 0, 16'h6666, 1, 1, 0));
      vecs.push_back(mk(1, 1, 48'h7777_8888_9999, 0, 16'h5555, 1, 1, 0));

      foreach (vecs[i]) begin
         drive_a(vecs[i].req, vecs[i].addr, vecs[i].cntr, vecs[i].clr);
         tick();
         check($sformatf("vec%0d_data", i),   if_a.RD_DATA_Q,  vecs[i].exp_data);
         check($sformatf("vec%0d_valid", i),  if_a.RD_VALID_Q, vecs[i].exp_valid);
         check($sformatf("vec%0d_active", i), active_a,        vecs[i].exp_active);
         check($sformatf("vec%0d_err", i),    err_a,           vecs[i].exp_err);
      end

      // reset mid-sequence takes effect without a clock edge
      drive_a(1'b0, 2'd0, 48'h7777_8888_9999, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_data",   if_a.RD_DATA_Q,  16'h0);
      check("midrst_valid",  if_a.RD_VALID_Q, 1'b0);
      check("midrst_active", active_a,        1'b0);
      tick();
      rst_n = 1'b1;
      model_reset();
      model_cycle("post_rst_stale", 1'b1, 2'd1, 48'h7777_8888_9999, 1'b0);
      check("post_rst_live", if_a.RD_DATA_Q, 16'h8888);
      model_cycle("post_rst_clr", 1'b0, 2'd0, 48'h7777_8888_9999, 1'b1);

      // randomized traffic against the model
      begin
         logic [47:0] c;
         c = 48'h0000_FFFF_FFF0;
         for (int n = 0; n < 600; n++) begin
            logic       r;
            logic [1:0] ad;
            logic       cl;
            if ($urandom_range(0, 3) == 0) c = {16'($urandom_range(0, 65535)), 32'($urandom())};
            else c = c + 48'd1;
            r  = ($urandom_range(0, 9) < 5);
            ad = 2'($urandom_range(0, 3));
            cl = ($urandom_range(0, 7) == 0);
            model_cycle("rnd", r, ad, c, cl);
         end
      end
      drive_a(1'b0, 2'd0, '0, 1'b0);

      // 40-bit counter: top word is zero-extended
      cntr_b = 40'hAB_CDEF_0123;
      drive_b(1'b1, 2'd0, 16'h0123, 1'b1, "w40_w0");
      cntr_b = 40'h00_0000_0000;
      drive_b(1'b1, 2'd1, 16'hCDEF, 1'b1, "w40_w1");
      drive_b(1'b1, 2'd2, 16'h00AB, 1'b0, "w40_w2");
      drive_b(1'b1, 2'd3, 16'h0000, 1'b0, "w40_oor");
      drive_b(1'b0, 2'd0, 16'h0000, 1'b0, "w40_hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
